// File: rtl/pmu_pkg.sv
// Shared types and header layout for the power-management key loader.
package pmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    START,
    WAIT,
    DONE,
    ERROR
  } pmu_state_t;

  localparam int MAGIC_LSB = 0;
  localparam int N_LSB     = 16;
  localparam int N_W       = 4;
  localparam int PAR_BIT   = 31;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hA5C3;

endpackage

// File: rtl/pmu_serial_shifter.sv
// LSB-first serial shift register with a bit counter and a done flag.
// Once WIDTH bits have been collected further shifts are ignored until cleared.
module pmu_serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_next,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_base;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_base;
  logic             done;
  logic             done_base;

  // Clear together with shift restarts the register holding only this cycle's bit.
  always_comb begin
    data_base  = clear ? '0 : data;
    count_base = clear ? '0 : count;
    done_base  = clear ? 1'b0 : done;
    data_next  = (data_base >> 1) | {bit_in, {(WIDTH-1){1'b0}}};
    last       = shift && !done_base && (count_base == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
      done  <= 1'b0;
    end else if (shift && !done_base) begin
      data  <= data_next;
      count <= count_base + CW'(1);
      done  <= last;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/pmu_keyload_ctrl.sv
// Multi-block power-management key loader: serial header + N cipher blocks, AES handshake.
// Define PMU_HDR_PARITY_EN to require even parity over header[31:0].
module pmu_keyload_ctrl
  import pmu_pkg::*;
#(
  parameter int          HEADER_WIDTH   = 32,
  parameter int          AES_DATA_WIDTH = 128,
  parameter int          MAX_BLOCKS     = 2,
  parameter logic [15:0] MAGIC          = DEFAULT_MAGIC,
  parameter int          AES_TIMEOUT    = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 data_i,
  input  logic                                 en,
  output logic                                 tdo,
  output logic                                 aes_start,
  output logic [AES_DATA_WIDTH-1:0]            aes_din,
  input  logic                                 aes_done,
  input  logic [AES_DATA_WIDTH-1:0]            aes_dout,
  output logic [MAX_BLOCKS*AES_DATA_WIDTH-1:0] key_o,
  output logic                                 key_valid,
  output logic                                 pwr_up_en,
  output logic                                 err
);

  localparam int BW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int TW = $clog2(AES_TIMEOUT + 1);
  localparam logic [N_W-1:0] MAX_N   = N_W'(MAX_BLOCKS);
  localparam logic [TW-1:0]  TO_LAST = TW'(AES_TIMEOUT - 1);

  pmu_state_t state;
  logic          en_q;
  logic [N_W-1:0] n_reg;
  logic [BW-1:0]  blk;
  logic [TW-1:0]  tcount;

  logic new_frame;
  logic hdr_shift, hdr_clear, hdr_last;
  logic cip_shift, cip_clear, cip_last;
  logic [HEADER_WIDTH-1:0]   hdr_next;
  logic [AES_DATA_WIDTH-1:0] cip_next;
  logic [15:0]    hdr_magic;
  logic [N_W-1:0] hdr_n;
  logic par_ok, hdr_ok, last_blk, timed_out, go_error;
  logic hdr_unused;

  pmu_serial_shifter #(.WIDTH(HEADER_WIDTH)) u_hdr_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (hdr_clear),
    .shift     (hdr_shift),
    .bit_in    (data_i),
    .data_next (hdr_next),
    .last      (hdr_last)
  );

  pmu_serial_shifter #(.WIDTH(AES_DATA_WIDTH)) u_cipher_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cip_clear),
    .shift     (cip_shift),
    .bit_in    (data_i),
    .data_next (cip_next),
    .last      (cip_last)
  );

  // A frame starts from IDLE on any en, but from DONE/ERROR only on an en rising edge.
  always_comb begin
    new_frame = en && ((state == IDLE) || (((state == DONE) || (state == ERROR)) && !en_q));
    hdr_shift = new_frame || ((state == HDR) && en);
    hdr_clear = new_frame || (state != HDR);
    cip_shift = (state == PAYLOAD) && en;
    cip_clear = (state != PAYLOAD);
    hdr_magic = hdr_next[MAGIC_LSB +: 16];
    hdr_n     = hdr_next[N_LSB +: N_W];
    hdr_unused = ^hdr_next;
`ifdef PMU_HDR_PARITY_EN
    par_ok = ~^hdr_next[PAR_BIT:MAGIC_LSB];
`else
    par_ok = 1'b1;
`endif
    hdr_ok    = (hdr_magic == MAGIC) && (hdr_n != '0) && (hdr_n <= MAX_N) && par_ok;
    last_blk  = ((N_W'(blk) + N_W'(1)) == n_reg);
    timed_out = (tcount >= TO_LAST);
    go_error  = ((state == HDR) && (!en || (hdr_last && !hdr_ok))) ||
                ((state == PAYLOAD) && !en) ||
                ((state == WAIT) && !aes_done && timed_out);
  end

  // The timeout counter starts in the aes_start cycle, so err rises AES_TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      en_q      <= 1'b0;
      tdo       <= 1'b0;
      aes_start <= 1'b0;
      aes_din   <= '0;
      key_o     <= '0;
      key_valid <= 1'b0;
      pwr_up_en <= 1'b0;
      err       <= 1'b0;
      n_reg     <= '0;
      blk       <= '0;
      tcount    <= '0;
    end else begin
      en_q      <= en;
      tdo       <= data_i;
      aes_start <= 1'b0;
      if (new_frame) begin
        state     <= HDR;
        err       <= 1'b0;
        key_valid <= 1'b0;
        pwr_up_en <= 1'b0;
        key_o     <= '0;
      end else if (go_error) begin
        state     <= ERROR;
        err       <= 1'b1;
        key_valid <= 1'b0;
        pwr_up_en <= 1'b0;
        key_o     <= '0;
      end else begin
        unique case (state)
          HDR: begin
            if (hdr_last) begin
              state <= PAYLOAD;
              n_reg <= hdr_n;
              blk   <= '0;
            end
          end
          PAYLOAD: begin
            if (cip_last) begin
              state     <= START;
              aes_start <= 1'b1;
              aes_din   <= cip_next;
              tcount    <= '0;
            end
          end
          START: begin
            state  <= WAIT;
            tcount <= tcount + TW'(1);
          end
          WAIT: begin
            if (aes_done) begin
              for (int i = 0; i < MAX_BLOCKS; i++) begin
                if (blk == BW'(i)) begin
                  key_o[i*AES_DATA_WIDTH +: AES_DATA_WIDTH] <= aes_dout;
                end
              end
              if (last_blk) begin
                state     <= DONE;
                key_valid <= 1'b1;
                pwr_up_en <= 1'b1;
              end else begin
                state <= PAYLOAD;
                blk   <= blk + BW'(1);
              end
            end else begin
              tcount <= tcount + TW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pmu_keyload_ctrl.sv
// Directed self-checking bench for pmu_keyload_ctrl with a behavioural AES responder.
module tb_pmu_keyload_ctrl;

  localparam logic [15:0]  MAGIC_OK = 16'hA5C3;
  localparam logic [127:0] XMASK = 128'h5A5A_F00F_1234_8765_C3C3_0FF0_9999_6666;
  localparam logic [127:0] C0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] C1 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1357_9BDF;
  localparam logic [127:0] P0 = C0 ^ XMASK;
  localparam logic [127:0] P1 = C1 ^ XMASK;

  logic         clk;
  logic         rst_n;
  logic         data_i;
  logic         en;
  logic         tdo;
  logic         aes_start;
  logic [127:0] aes_din;
  logic         aes_done;
  logic [127:0] aes_dout;
  logic [255:0] key_o;
  logic         key_valid;
  logic         pwr_up_en;
  logic         err;

  int vectors = 0;
  int miscompares = 0;
  int start_count = 0;
  int aes_delay = 10;
  bit aes_respond = 1'b1;
  int inject_req = 0;

  pmu_keyload_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_i    (data_i),
    .en        (en),
    .tdo       (tdo),
    .aes_start (aes_start),
    .aes_din   (aes_din),
    .aes_done  (aes_done),
    .aes_dout  (aes_dout),
    .key_o     (key_o),
    .key_valid (key_valid),
    .pwr_up_en (pwr_up_en),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AES responder: plaintext = ciphertext ^ XMASK, aes_delay cycles after aes_start.
  initial begin
    int cnt;
    bit pend;
    int inject_ack;
    logic [127:0] held;
    cnt = 0; pend = 1'b0; inject_ack = 0; held = '0;
    aes_done = 1'b0;
    aes_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      aes_done = 1'b0;
      if (aes_start) begin
        start_count++;
        pend = aes_respond;
        cnt  = aes_delay;
        held = aes_din ^ XMASK;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          aes_done = 1'b1;
          aes_dout = held;
          pend = 1'b0;
        end
      end
      if (inject_req != inject_ack) begin
        inject_ack = inject_req;
        aes_done = 1'b1;
        aes_dout = '1;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en = 1'b1;
    data_i = b;
    tick();
  endtask

  task automatic idle_low(input int n);
    en = 1'b0;
    data_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bits(input logic [127:0] v, input int first, input int last);
    for (int i = first; i <= last; i++) send_bit(v[i]);
  endtask

  function automatic logic [31:0] make_hdr(input logic [15:0] magic, input logic [3:0] n);
    logic [30:0] body;
    body = {11'h0, n, magic};
    return {^body, body};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; data_i = 1'b1;
    tick(); tick();
    vectors++; if (tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tdo: got %0b want 0", tdo); end
    vectors++; if (aes_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_aes_start: got %0b want 0", aes_start); end
    vectors++; if (aes_din !== '0) begin miscompares++; $display("[TB] FAIL reset_aes_din: got %h want 0", aes_din); end
    vectors++; if (key_o !== '0) begin miscompares++; $display("[TB] FAIL reset_key_o: got %h want 0", key_o); end
    vectors++; if ({key_valid, pwr_up_en, err} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", {key_valid, pwr_up_en, err}); end
    rst_n = 1'b1;
    data_i = 1'b1; tick();
    vectors++; if (tdo !== 1'b1) begin miscompares++; $display("[TB] FAIL tdo_one: got %0b want 1", tdo); end
    data_i = 1'b0; tick();
    vectors++; if (tdo !== 1'b0) begin miscompares++; $display("[TB] FAIL tdo_zero: got %0b want 0", tdo); end
  endtask

  task automatic test_single_block();
    int cycles;
    int sc0;
    sc0 = start_count;
    send_bits({96'h0, make_hdr(MAGIC_OK, 4'd1)}, 0, 31);
    send_bits(C0, 0, 126);
    vectors++; if (aes_start !== 1'b0) begin miscompares++; $display("[TB] FAIL n1_early_start: got %0b want 0", aes_start); end
    send_bit(C0[127]);
    vectors++; if (aes_start !== 1'b1) begin miscompares++; $display("[TB] FAIL n1_start: got %0b want 1", aes_start); end
    vectors++; if (aes_din !== C0) begin miscompares++; $display("[TB] FAIL n1_aes_din: got %h want %h", aes_din, C0); end
    en = 1'b0; data_i = 1'b0;
    cycles = 0;
    while (pwr_up_en !== 1'b1 && cycles < 40) begin tick(); cycles++; end
    vectors++; if (cycles != 11) begin miscompares++; $display("[TB] FAIL n1_pwr_latency: got %0d want 11", cycles); end
    vectors++; if (key_o !== {128'h0, P0}) begin miscompares++; $display("[TB] FAIL n1_key: got %h want %h", key_o, {128'h0, P0}); end
    vectors++; if ({key_valid, err} !== 2'b10) begin miscompares++; $display("[TB] FAIL n1_flags: got %b want 10", {key_valid, err}); end
    vectors++; if (start_count - sc0 != 1) begin miscompares++; $display("[TB] FAIL n1_start_count: got %0d want 1", start_count - sc0); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int sc0;
    logic [31:0] h;
    sc0 = start_count;
    h = make_hdr(MAGIC_OK, 4'd2);
    send_bit(h[0]);
    vectors++; if ({pwr_up_en, key_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL n2_restart_flags: got %b want 00", {pwr_up_en, key_valid}); end
    vectors++; if (key_o !== '0) begin miscompares++; $display("[TB] FAIL n2_restart_key: got %h want 0", key_o); end
    send_bits({96'h0, h}, 1, 31);
    send_bits(C0, 0, 127);
    for (int i = 0; i < 11; i++) send_bit(i[0]);
    vectors++; if (key_o[127:0] !== P0) begin miscompares++; $display("[TB] FAIL n2_block0: got %h want %h", key_o[127:0], P0); end
    vectors++; if ({key_valid, pwr_up_en} !== 2'b00) begin miscompares++; $display("[TB] FAIL n2_mid_flags: got %b want 00", {key_valid, pwr_up_en}); end
    send_bits(C1, 0, 127);
    en = 1'b0; data_i = 1'b0;
    cycles = 0;
    while (pwr_up_en !== 1'b1 && cycles < 40) begin tick(); cycles++; end
    vectors++; if (cycles != 11) begin miscompares++; $display("[TB] FAIL n2_pwr_latency: got %0d want 11", cycles); end
    vectors++; if (key_o !== {P1, P0}) begin miscompares++; $display("[TB] FAIL n2_key: got %h want %h", key_o, {P1, P0}); end
    vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL n2_key_valid: got %0b want 1", key_valid); end
    vectors++; if (start_count - sc0 != 2) begin miscompares++; $display("[TB] FAIL n2_start_count: got %0d want 2", start_count - sc0); end
  endtask

  task automatic test_bad_magic();
    int sc0;
    sc0 = start_count;
    idle_low(1);
    send_bits({96'h0, make_hdr(16'hA5C2, 4'd1)}, 0, 30);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL magic_err_early: got %0b want 0", err); end
    vectors++; if (key_o !== '0) begin miscompares++; $display("[TB] FAIL magic_key_cleared: got %h want 0", key_o); end
    send_bit(make_hdr(16'hA5C2, 4'd1) >> 31);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL magic_err: got %0b want 1", err); end
    send_bits(C0, 0, 127);
    repeat (15) send_bit(1'b0);
    vectors++; if (start_count - sc0 != 0) begin miscompares++; $display("[TB] FAIL magic_no_start: got %0d want 0", start_count - sc0); end
    vectors++; if ({pwr_up_en, err} !== 2'b01) begin miscompares++; $display("[TB] FAIL magic_flags: got %b want 01", {pwr_up_en, err}); end
  endtask

  task automatic test_bad_count();
    logic [3:0] ns [2];
    logic [31:0] h;
    ns[0] = 4'd0;
    ns[1] = 4'd3;
    for (int k = 0; k < 2; k++) begin
      h = make_hdr(MAGIC_OK, ns[k]);
      idle_low(1);
      send_bit(h[0]);
      vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL count%0d_err_cleared: got %0b want 0", ns[k], err); end
      send_bits({96'h0, h}, 1, 31);
      vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL count%0d_err: got %0b want 1", ns[k], err); end
    end
  endtask

  task automatic test_abort();
    int cycles;
    idle_low(1);
    send_bits({96'h0, make_hdr(MAGIC_OK, 4'd1)}, 0, 31);
    send_bits(C0, 0, 69);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_err_early: got %0b want 0", err); end
    idle_low(1);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_err: got %0b want 1", err); end
    vectors++; if ({key_o, key_valid} !== '0) begin miscompares++; $display("[TB] FAIL abort_key: got %h/%0b want 0", key_o, key_valid); end
    send_bits({96'h0, make_hdr(MAGIC_OK, 4'd1)}, 0, 31);
    send_bits(C1, 0, 127);
    en = 1'b0; data_i = 1'b0;
    cycles = 0;
    while (pwr_up_en !== 1'b1 && cycles < 40) begin tick(); cycles++; end
    vectors++; if (cycles != 11) begin miscompares++; $display("[TB] FAIL abort_recover_latency: got %0d want 11", cycles); end
    vectors++; if ({key_o, err} !== {128'h0, P1, 1'b0}) begin miscompares++; $display("[TB] FAIL abort_recover_key: got %h/%0b want %h/0", key_o, err, P1); end
  endtask

  task automatic test_timeout();
    aes_respond = 1'b0;
    idle_low(1);
    send_bits({96'h0, make_hdr(MAGIC_OK, 4'd1)}, 0, 31);
    send_bits(C0, 0, 127);
    vectors++; if (aes_start !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_start: got %0b want 1", aes_start); end
    en = 1'b0; data_i = 1'b0;
    repeat (63) tick();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_err_early: got %0b want 0", err); end
    tick();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %0b want 1", err); end
    vectors++; if ({pwr_up_en, key_valid} !== 2'b00) begin miscompares++; $display("[TB] FAIL timeout_flags: got %b want 00", {pwr_up_en, key_valid}); end
    aes_respond = 1'b1;
  endtask

  task automatic test_done_wins();
    int cycles;
    aes_delay = 63;
    idle_low(1);
    send_bits({96'h0, make_hdr(MAGIC_OK, 4'd1)}, 0, 31);
    send_bits(C1, 0, 127);
    en = 1'b0; data_i = 1'b0;
    cycles = 0;
    while (pwr_up_en !== 1'b1 && err !== 1'b1 && cycles < 100) begin tick(); cycles++; end
    vectors++; if ({pwr_up_en, err} !== 2'b10) begin miscompares++; $display("[TB] FAIL edge_done_flags: got %b want 10", {pwr_up_en, err}); end
    vectors++; if (cycles != 64) begin miscompares++; $display("[TB] FAIL edge_done_latency: got %0d want 64", cycles); end
    aes_delay = 10;
    inject_req++;
    repeat (3) tick();
    vectors++; if (key_o !== {128'h0, P1}) begin miscompares++; $display("[TB] FAIL stray_done_key: got %h want %h", key_o, {128'h0, P1}); end
    vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stray_done_valid: got %0b want 1", key_valid); end
  endtask

`ifdef PMU_HDR_PARITY_EN
  task automatic test_parity();
    logic [31:0] h;
    h = make_hdr(MAGIC_OK, 4'd1) ^ 32'h8000_0000;
    idle_low(1);
    send_bits({96'h0, h}, 0, 31);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL parity_err: got %0b want 1", err); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    data_i = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_bad_magic();
    test_bad_count();
    test_abort();
    test_timeout();
    test_done_wins();
`ifdef PMU_HDR_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
